bouncing_box_renderer: RTL and testbench

- Pixel-colour stage directly downstream of the pixel-index-to-coordinate converter on the 96x64 OLED path.
- Takes the current pixel's x/y and returns registered RGB565 data for the OLED driver.
- Draws a 1-px border and a square box that moves diagonally and bounces off the inner edges.
- The box position updates only at frame boundaries, so no tearing occurs.

---
 rtl/bouncing_box_renderer.sv | 129 ++++++++++++
 tb/tb_bouncing_box_renderer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bouncing_box_renderer.sv
// rtl/bouncing_box_renderer.sv - RGB565 pixel colour stage drawing a border and a bouncing box
`timescale 1ns/1ps
module bouncing_box_renderer #(
  parameter int          WIDTH         = 96,
  parameter int          HEIGHT        = 64,
  parameter int          BOX_SIZE      = 8,
  parameter int          FRAME_DIV     = 2,
  parameter int          START_X       = 8,
  parameter int          START_Y       = 4,
  parameter logic [15:0] BOX_COLOUR    = 16'hF800,
  parameter logic [15:0] BORDER_COLOUR = 16'h07E0,
  parameter logic [15:0] BG_COLOUR     = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frame_begin,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic [15:0] oled_data,
  output logic [7:0]  box_x,
  output logic [7:0]  box_y,
  output logic        hit
);

  localparam logic [7:0] XMIN    = 8'd1;
  localparam logic [7:0] YMIN    = 8'd1;
  localparam logic [7:0] XMAX    = 8'(WIDTH - 1 - BOX_SIZE);
  localparam logic [7:0] YMAX    = 8'(HEIGHT - 1 - BOX_SIZE);
  localparam logic [7:0] W_END   = 8'(WIDTH);
  localparam logic [7:0] H_END   = 8'(HEIGHT);
  localparam logic [7:0] W_LAST  = 8'(WIDTH - 1);
  localparam logic [7:0] H_LAST  = 8'(HEIGHT - 1);
  localparam logic [7:0] BOX_EXT = 8'(BOX_SIZE - 1);
  localparam int         CW      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

  typedef enum logic {IDLE, STEP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   oled_data_q, oled_data_d;
  logic [7:0]    box_x_q, box_x_d;
  logic [7:0]    box_y_q, box_y_d;
  logic          dir_x_q, dir_x_d;
  logic          dir_y_q, dir_y_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          hit_q, hit_d;
  logic          frame_begin_q, frame_begin_d;
  logic          fb_edge;
  logic          flip_x, flip_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      oled_data_q   <= BG_COLOUR;
      box_x_q       <= 8'(START_X);
      box_y_q       <= 8'(START_Y);
      dir_x_q       <= 1'b1;
      dir_y_q       <= 1'b1;
      frame_cnt_q   <= '0;
      hit_q         <= 1'b0;
      frame_begin_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      oled_data_q   <= oled_data_d;
      box_x_q       <= box_x_d;
      box_y_q       <= box_y_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      frame_cnt_q   <= frame_cnt_d;
      hit_q         <= hit_d;
      frame_begin_q <= frame_begin_d;
    end
  end

  // Direction bit: 1 moves toward larger coordinates, 0 toward smaller.
  always_comb begin
    state_d       = state_q;
    box_x_d       = box_x_q;
    box_y_d       = box_y_q;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    frame_cnt_d   = frame_cnt_q;
    hit_d         = 1'b0;
    frame_begin_d = frame_begin;
    fb_edge       = frame_begin & ~frame_begin_q;
    flip_x        = (dir_x_q && box_x_q == XMAX) || (!dir_x_q && box_x_q == XMIN);
    flip_y        = (dir_y_q && box_y_q == YMAX) || (!dir_y_q && box_y_q == YMIN);

    case (state_q)
      IDLE: begin
        if (fb_edge && enable) begin
          if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_d = '0;
            state_d     = STEP;
          end else begin
            frame_cnt_d = frame_cnt_q + CW'(1);
          end
        end
      end
      STEP: begin
        if (flip_x) dir_x_d = ~dir_x_q;
        if (flip_y) dir_y_d = ~dir_y_q;
        box_x_d = (dir_x_q ^ flip_x) ? box_x_q + 8'd1 : box_x_q - 8'd1;
        box_y_d = (dir_y_q ^ flip_y) ? box_y_q + 8'd1 : box_y_q - 8'd1;
        hit_d   = flip_x | flip_y;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    oled_data_d = BG_COLOUR;
    if (x >= W_END || y >= H_END)
      oled_data_d = BG_COLOUR;
    else if (x == 8'd0 || x == W_LAST || y == 8'd0 || y == H_LAST)
      oled_data_d = BORDER_COLOUR;
    else if (x >= box_x_q && x <= box_x_q + BOX_EXT &&
             y >= box_y_q && y <= box_y_q + BOX_EXT)
      oled_data_d = BOX_COLOUR;
  end

  assign oled_data = oled_data_q;
  assign box_x     = box_x_q;
  assign box_y     = box_y_q;
  assign hit       = hit_q;

endmodule

// File: tb/tb_bouncing_box_renderer.sv
// tb/tb_bouncing_box_renderer.sv - randomized bench for bouncing_box_renderer with behavioural model
`timescale 1ns/1ps
module tb_bouncing_box_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        frame_begin = 1'b0;
  logic [7:0]  x = 8'd0;
  logic [7:0]  y = 8'd0;
  logic [15:0] od [3];
  logic [7:0]  bx [3];
  logic [7:0]  by [3];
  logic        hit [3];

  int checks = 0;
  int errors = 0;

  localparam int SX [3]  = '{8, 86, 86};
  localparam int SY [3]  = '{4, 10, 54};
  localparam int DIV [3] = '{2, 1, 1};

  int          mx [3], my [3], mdx [3], mdy [3], mcnt [3];
  bit          mpend [3], mhit [3];
  logic [15:0] mo [3];
  bit          fbprev;
  int          hcnt [3];

  always #5 clk = ~clk;

  bouncing_box_renderer #(.FRAME_DIV(2), .START_X(8), .START_Y(4)) d0 (
    .clk(clk), .reset(reset), .enable(enable), .frame_begin(frame_begin), .x(x), .y(y),
    .oled_data(od[0]), .box_x(bx[0]), .box_y(by[0]), .hit(hit[0]));
  bouncing_box_renderer #(.FRAME_DIV(1), .START_X(86), .START_Y(10)) d1 (
    .clk(clk), .reset(reset), .enable(enable), .frame_begin(frame_begin), .x(x), .y(y),
    .oled_data(od[1]), .box_x(bx[1]), .box_y(by[1]), .hit(hit[1]));
  bouncing_box_renderer #(.FRAME_DIV(1), .START_X(86), .START_Y(54)) d2 (
    .clk(clk), .reset(reset), .enable(enable), .frame_begin(frame_begin), .x(x), .y(y),
    .oled_data(od[2]), .box_x(bx[2]), .box_y(by[2]), .hit(hit[2]));

  function automatic logic [15:0] render(int px, int py, int bxx, int byy);
    if (px >= 96 || py >= 64) return 16'h0000;
    if (px == 0 || px == 95 || py == 0 || py == 63) return 16'h07E0;
    if (px >= bxx && px < bxx + 8 && py >= byy && py < byy + 8) return 16'hF800;
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = SX[i]; my[i] = SY[i]; mdx[i] = 1; mdy[i] = 1;
      mcnt[i] = 0; mpend[i] = 0; mhit[i] = 0; mo[i] = 16'h0000;
    end
    fbprev = 0;
  endtask

  // One clock of the reference: box reflects off the walls at 1 and 87/55.
  task automatic model_clock();
    int nx, ny;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      mo[i]   = render(int'(x), int'(y), mx[i], my[i]);
      mhit[i] = 0;
      if (mpend[i]) begin
        nx = mx[i] + mdx[i];
        ny = my[i] + mdy[i];
        if (nx > 87 || nx < 1) begin mdx[i] = -mdx[i]; nx = mx[i] + mdx[i]; mhit[i] = 1; end
        if (ny > 55 || ny < 1) begin mdy[i] = -mdy[i]; ny = my[i] + mdy[i]; mhit[i] = 1; end
        mx[i] = nx; my[i] = ny; mpend[i] = 0;
      end else if (frame_begin && !fbprev && enable) begin
        if (mcnt[i] == DIV[i] - 1) begin mcnt[i] = 0; mpend[i] = 1; end
        else mcnt[i] = mcnt[i] + 1;
      end
    end
    fbprev = frame_begin;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("oled%0d", i), int'(od[i]), int'(mo[i]));
      check($sformatf("box_x%0d", i), int'(bx[i]), mx[i]);
      check($sformatf("box_y%0d", i), int'(by[i]), my[i]);
      check($sformatf("hit%0d", i), int'(hit[i]), int'(mhit[i]));
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
    for (int i = 0; i < 3; i++) hcnt[i] += int'(hit[i]);
  endtask

  task automatic pulse(input int len);
    frame_begin = 1'b1;
    repeat (len) step_cycle();
    frame_begin = 1'b0;
    repeat (4) step_cycle();
  endtask

  typedef struct { int px; int py; int col; } rcase_t;
  rcase_t rtab [6] = '{'{8, 4, 16'hF800}, '{15, 11, 16'hF800}, '{16, 4, 16'h0000},
                       '{0, 10, 16'h07E0}, '{95, 63, 16'h07E0}, '{100, 5, 16'h0000}};

  initial begin
    model_reset();
    #2 reset = 1'b1;
    enable = 1'b1;
    repeat (2) step_cycle();
    reset = 1'b0;
    check("rst_oled", int'(od[0]), 16'h0000);
    check("rst_box_x", int'(bx[0]), 8);
    check("rst_box_y", int'(by[0]), 4);
    check("rst_hit", int'(hit[0]), 0);

    foreach (rtab[k]) begin
      x = 8'(rtab[k].px); y = 8'(rtab[k].py);
      step_cycle();
      check($sformatf("render_%0d_%0d", rtab[k].px, rtab[k].py), int'(od[0]), rtab[k].col);
    end

    for (int i = 0; i < 3; i++) hcnt[i] = 0;
    pulse(1);
    check("p1_box0", int'({bx[0], by[0]}), {8'd8, 8'd4});
    check("p1_box1", int'({bx[1], by[1]}), {8'd87, 8'd11});
    check("p1_box2", int'({bx[2], by[2]}), {8'd87, 8'd55});
    check("p1_hits1", hcnt[1], 0);

    for (int i = 0; i < 3; i++) hcnt[i] = 0;
    frame_begin = 1'b1;
    step_cycle();
    check("lat_clk1", int'(bx[0]), 8);
    step_cycle();
    check("lat_clk2", int'({bx[0], by[0]}), {8'd9, 8'd5});
    frame_begin = 1'b0;
    repeat (4) step_cycle();
    check("p2_box1", int'({bx[1], by[1]}), {8'd86, 8'd12});
    check("p2_box2", int'({bx[2], by[2]}), {8'd86, 8'd54});
    check("p2_hits1", hcnt[1], 1);
    check("p2_hits2", hcnt[2], 1);

    pulse(5);
    check("held_box0", int'({bx[0], by[0]}), {8'd9, 8'd5});
    check("p3_box1", int'({bx[1], by[1]}), {8'd85, 8'd13});
    check("p3_box2", int'({bx[2], by[2]}), {8'd85, 8'd53});

    enable = 1'b0;
    x = 8'd10; y = 8'd6;
    repeat (4) pulse(1);
    check("freeze_box0", int'({bx[0], by[0]}), {8'd9, 8'd5});
    check("freeze_box1", int'({bx[1], by[1]}), {8'd85, 8'd13});
    check("freeze_render", int'(od[0]), 16'hF800);
    enable = 1'b1;

    frame_begin = 1'b1;
    step_cycle();
    #1 reset = 1'b1;
    #1;
    check("async_oled", int'(od[0]), 16'h0000);
    check("async_box0", int'({bx[0], by[0]}), {8'd8, 8'd4});
    check("async_box1", int'({bx[1], by[1]}), {8'd86, 8'd10});
    check("async_hit", int'(hit[0]), 0);
    model_reset();
    frame_begin = 1'b0;
    step_cycle();
    reset = 1'b0;
    step_cycle();
    pulse(1);
    pulse(1);
    check("post_rst_box0", int'({bx[0], by[0]}), {8'd9, 8'd5});

    for (int n = 0; n < 3000; n++) begin
      x = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 100));
      y = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 70));
      if ($urandom % 6 == 0) frame_begin = ~frame_begin;
      enable = ($urandom % 10) != 0;
      reset = ($urandom % 700) == 0;
      step_cycle();
    end
    reset = 1'b0;
    step_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
